// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter between an instruction-fetch port and a data port
// sharing one byte-wide RAM; multi-byte items are moved big-endian, one byte per cycle.
module mem_arbiter_ctrl #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 IReq,
  input  logic [31:0]          IAddress,
  output logic [31:0]          IDataOut,
  output logic                 IDone,
  input  logic                 DReq,
  input  logic                 DReadWrite,
  input  logic [1:0]           DSize,
  input  logic [31:0]          DAddress,
  input  logic [31:0]          DDataIn,
  output logic [31:0]          DDataOut,
  output logic                 DDone,
  output logic                 RamEnable,
  output logic                 RamReadWrite,
  output logic [ADDR_BITS-1:0] RamAddress,
  output logic [7:0]           RamDataIn,
  input  logic [7:0]           RamDataOut,
  output logic                 Error,
  output logic                 Busy,
  output logic [1:0]           DbgState
);

  // Handshake: a requester holds its Req level until it sees its one-cycle Done
  // pulse (Error qualifies it); Req is only sampled in IDLE, so a Req still high
  // in the IDLE after DONE is a new request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   lastgnt_q, lastgnt_d;  // 1: data port granted last
  logic                   port_q, port_d;        // 1: data port owns the access
  logic                   rw_q, rw_d;
  logic                   err_q, err_d;
  logic [1:0]             nlast_q, nlast_d;      // byte count minus one
  logic [1:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            asm_q, asm_d;
  logic [31:0]            idata_q, idata_d;
  logic [31:0]            ddata_q, ddata_d;

  logic                   grant;
  logic [1:0]             sel_size;
  logic [31:0]            sel_addr;
  logic                   sel_err;
  logic [31:0]            asm_next;
  logic [1:0]             byte_sel;
  logic                   access;
  logic                   unused_hi;

  // On conflict the port that was not granted last wins.
  assign grant    = DReq & (~IReq | ~lastgnt_q);
  assign sel_size = grant ? DSize : 2'b10;
  assign sel_addr = grant ? DAddress : IAddress;
  assign sel_err  = (sel_size == 2'b11) ||
                    ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00)) ||
                    ((sel_size == 2'b01) && sel_addr[0]);
  assign asm_next = {asm_q[23:0], RamDataOut};
  assign unused_hi = ^sel_addr[31:ADDR_BITS];

  always_comb begin
    state_d   = state_q;
    lastgnt_d = lastgnt_q;
    port_d    = port_q;
    rw_d      = rw_q;
    err_d     = err_q;
    nlast_d   = nlast_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    asm_d     = asm_q;
    idata_d   = idata_q;
    ddata_d   = ddata_q;
    case (state_q)
      IDLE: begin
        if (IReq || DReq) begin
          lastgnt_d = grant;
          port_d    = grant;
          rw_d      = grant & DReadWrite;
          err_d     = sel_err;
          addr_d    = sel_addr[ADDR_BITS-1:0];
          wdata_d   = grant ? DDataIn : 32'h0;
          nlast_d   = (sel_size == 2'b00) ? 2'd0 : (sel_size == 2'b01) ? 2'd1 : 2'd3;
          cnt_d     = 2'd0;
          asm_d     = 32'h0;
          state_d   = sel_err ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (!rw_q) asm_d = asm_next;
        if (cnt_q == nlast_q) begin
          cnt_d   = 2'd0;
          state_d = DONE;
          // Read result becomes visible on DONE entry, including the final byte.
          if (!rw_q) begin
            if (port_q) ddata_d = asm_next;
            else        idata_d = asm_next;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      lastgnt_q <= 1'b0;
      port_q    <= 1'b0;
      rw_q      <= 1'b0;
      err_q     <= 1'b0;
      nlast_q   <= 2'd0;
      cnt_q     <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      asm_q     <= 32'h0;
      idata_q   <= 32'h0;
      ddata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      lastgnt_q <= lastgnt_d;
      port_q    <= port_d;
      rw_q      <= rw_d;
      err_q     <= err_d;
      nlast_q   <= nlast_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      asm_q     <= asm_d;
      idata_q   <= idata_d;
      ddata_q   <= ddata_d;
    end
  end

  assign access       = (state_q == ACCESS);
  assign byte_sel     = nlast_q - cnt_q;
  assign RamEnable    = access;
  assign RamReadWrite = access & rw_q;
  assign RamAddress   = access ? (addr_q + ADDR_BITS'(cnt_q)) : '0;
  assign RamDataIn    = (access && rw_q) ? wdata_q[{byte_sel, 3'b000} +: 8] : 8'h0;
  assign IDone        = (state_q == DONE) & ~port_q;
  assign DDone        = (state_q == DONE) & port_q;
  assign Error        = (state_q == DONE) & err_q;
  assign Busy         = (state_q != IDLE);
  assign IDataOut     = idata_q;
  assign DDataOut     = ddata_q;
  assign DbgState     = state_q;

endmodule
